// File: rtl/phy_link_ctrl.sv
// Link-training / data-gating controller for the 4-lane byte-striped PHY.
// Optional build macro PHY_LINK_CTRL_STRIP_COM_EN drops COM bytes from validout while ACTIVE.

module phy_link_lane #(
    parameter logic [7:0] COM_SYM = 8'hBC,
    parameter int         COM_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] din,
    input  logic       vld,
    output logic       lock
);
    localparam logic [3:0] CNT_LIM = 4'(COM_CNT);

    logic [3:0] cnt_q, cnt_d;
    logic       lock_q, lock_d;

    always_comb begin
        cnt_d  = cnt_q;
        lock_d = lock_q;
        if (clr) begin
            cnt_d  = '0;
            lock_d = 1'b0;
        end else if (en && vld) begin
            if (din == COM_SYM) begin
                if (cnt_q < CNT_LIM) cnt_d = cnt_q + 4'd1;
                lock_d = lock_q | (cnt_d == CNT_LIM);
            end else begin
                cnt_d  = '0;
                lock_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
        end
    end

    assign lock = lock_q;
endmodule

module phy_link_ctrl #(
    parameter logic [7:0] COM_SYM    = 8'hBC,
    parameter int         COM_CNT    = 4,
    parameter int         LOSS_MAX   = 3,
    parameter int         RECOVER_TO = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic [3:0] validin,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic [3:0] validout,
    output logic [3:0] lane_lock,
    output logic       link_up,
    output logic [1:0] state
);
    localparam int         NUM_LANES = 4;
    localparam logic [3:0] LOSS_LIM  = 4'(LOSS_MAX);
    localparam logic [7:0] TO_LIM    = 8'(RECOVER_TO);

    typedef enum logic [1:0] {ST_RESET, ST_SYNC, ST_ACTIVE, ST_RECOVER} state_e;

    state_e                          state_q, state_d;
    logic [NUM_LANES-1:0][7:0]       din, out_q, out_d;
    logic [NUM_LANES-1:0]            vout_q, vout_d, com_hit, lock;
    logic [3:0]                      loss_q, loss_d;
    logic [7:0]                      to_q, to_d;
    logic                            lock_clr;

    assign din = {in3, in2, in1, in0};

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        assign com_hit[n] = (din[n] == COM_SYM);
        phy_link_lane #(.COM_SYM(COM_SYM), .COM_CNT(COM_CNT)) u_lane (
            .clk  (clk),
            .reset(reset),
            .en   (state_q == ST_SYNC),
            .clr  (lock_clr),
            .din  (din[n]),
            .vld  (validin[n]),
            .lock (lock[n])
        );
    end

    always_comb begin
        state_d  = state_q;
        loss_d   = loss_q;
        to_d     = to_q;
        out_d    = '0;
        vout_d   = '0;
        lock_clr = 1'b0;
        unique case (state_q)
            ST_RESET: state_d = ST_SYNC;
            ST_SYNC:  if (&lock) state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                out_d  = din;
`ifdef PHY_LINK_CTRL_STRIP_COM_EN
                vout_d = validin & ~com_hit;
`else
                vout_d = validin;
`endif
                if (validin != 4'hF) begin
                    if (loss_q < LOSS_LIM) loss_d = loss_q + 4'd1;
                end else begin
                    loss_d = '0;
                end
                // Gate valids on the very edge we drop into RECOVER.
                if (loss_d == LOSS_LIM) begin
                    state_d = ST_RECOVER;
                    vout_d  = '0;
                end
            end
            ST_RECOVER: begin
                out_d = out_q;
                if ((validin == 4'hF) && (&com_hit)) begin
                    state_d = ST_ACTIVE;
                    loss_d  = '0;
                    to_d    = '0;
                end else begin
                    if (to_q < TO_LIM) to_d = to_q + 8'd1;
                    if (to_d == TO_LIM) begin
                        state_d  = ST_SYNC;
                        loss_d   = '0;
                        to_d     = '0;
                        out_d    = '0;
                        lock_clr = 1'b1;
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
            out_q   <= '0;
            vout_q  <= '0;
            loss_q  <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            vout_q  <= vout_d;
            loss_q  <= loss_d;
            to_q    <= to_d;
        end
    end

    assign {out3, out2, out1, out0} = out_q;
    assign validout  = vout_q;
    assign lane_lock = lock;
    assign link_up   = (state_q == ST_ACTIVE);
    assign state     = state_q;
endmodule
